// File: rtl/ysyx_220053_id_ex_if.sv
// ID->EX stage bundle: ID-side request, bypass sources, flush and the EX-side held entry.
// The stage itself takes the slave view; the surrounding pipeline takes the master view.
interface ysyx_220053_id_ex_if #(
  parameter int XLEN = 64,
  parameter int OPW  = 4
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      in_rs1_addr;
  logic [4:0]      in_rs2_addr;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic            in_asel;
  logic            in_bsel;
  logic [OPW-1:0]  in_aluop;
  logic [4:0]      in_rd;
  logic            in_wen;
  logic            exm_wen;
  logic [4:0]      exm_rd;
  logic [XLEN-1:0] exm_data;
  logic            wb_wen;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] inputa;
  logic [XLEN-1:0] inputb;
  logic [OPW-1:0]  ALUOp;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic            out_wen;

  modport slave (
    input  flush, in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_asel, in_bsel, in_aluop, in_rd, in_wen,
           exm_wen, exm_rd, exm_data, wb_wen, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, inputa, inputb, ALUOp, out_rs2_data, out_pc, out_rd, out_wen
  );

  modport master (
    output flush, in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_asel, in_bsel, in_aluop, in_rd, in_wen,
           exm_wen, exm_rd, exm_data, wb_wen, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, inputa, inputb, ALUOp, out_rs2_data, out_pc, out_rd, out_wen
  );
endinterface

// File: rtl/ysyx_220053_id_ex_stage.sv
// ID->EX pipeline register: resolves EX/MEM and MEM/WB bypass at capture time, selects
// ALU operands and holds one instruction under valid/ready with flush on redirect.
module ysyx_220053_id_ex_stage #(
  parameter int XLEN = 64,
  parameter int OPW  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  ysyx_220053_id_ex_if.slave   bus
);

  logic            out_valid_r;
  logic [XLEN-1:0] inputa_r;
  logic [XLEN-1:0] inputb_r;
  logic [XLEN-1:0] rs2_r;
  logic [XLEN-1:0] pc_r;
  logic [OPW-1:0]  aluop_r;
  logic [4:0]      rd_r;
  logic            wen_r;

  logic            in_ready_s;
  logic            capture_s;
  logic [XLEN-1:0] fwd_rs1_s;
  logic [XLEN-1:0] fwd_rs2_s;
  logic [XLEN-1:0] opa_s;
  logic [XLEN-1:0] opb_s;
  logic            wen_s;

  // x0 reads as zero; the younger EX/MEM result wins over MEM/WB.
  function automatic logic [XLEN-1:0] bypass(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_data,
    input logic            exm_wen,
    input logic [4:0]      exm_rd,
    input logic [XLEN-1:0] exm_data,
    input logic            wb_wen,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] res;
    if (addr == 5'd0) begin
      res = {XLEN{1'b0}};
    end else if (exm_wen && (exm_rd == addr)) begin
      res = exm_data;
    end else if (wb_wen && (wb_rd == addr)) begin
      res = wb_data;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

  // Handshake, bypass resolution and operand selection for the entry being captured.
  always_comb begin
    in_ready_s = !out_valid_r || bus.out_ready;
    capture_s  = bus.in_valid && in_ready_s && !bus.flush;
    fwd_rs1_s  = bypass(bus.in_rs1_addr, bus.in_rs1_data, bus.exm_wen, bus.exm_rd,
                        bus.exm_data, bus.wb_wen, bus.wb_rd, bus.wb_data);
    fwd_rs2_s  = bypass(bus.in_rs2_addr, bus.in_rs2_data, bus.exm_wen, bus.exm_rd,
                        bus.exm_data, bus.wb_wen, bus.wb_rd, bus.wb_data);
    if (bus.in_asel) begin
      opa_s = bus.in_pc;
    end else begin
      opa_s = fwd_rs1_s;
    end
    if (bus.in_bsel) begin
      opb_s = bus.in_imm;
    end else begin
      opb_s = fwd_rs2_s;
    end
    // A write to x0 is architecturally a no-op, so never advertise it downstream.
    wen_s = bus.in_wen && (bus.in_rd != 5'd0);
  end

  // Valid tracking: flush dominates, then capture, then drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
    end else if (bus.flush) begin
      out_valid_r <= 1'b0;
    end else if (capture_s) begin
      out_valid_r <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Payload registers load only on capture; held entries are never re-forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inputa_r <= {XLEN{1'b0}};
      inputb_r <= {XLEN{1'b0}};
      rs2_r    <= {XLEN{1'b0}};
      pc_r     <= {XLEN{1'b0}};
      aluop_r  <= {OPW{1'b0}};
      rd_r     <= 5'd0;
      wen_r    <= 1'b0;
    end else if (capture_s) begin
      inputa_r <= opa_s;
      inputb_r <= opb_s;
      rs2_r    <= fwd_rs2_s;
      pc_r     <= bus.in_pc;
      aluop_r  <= bus.in_aluop;
      rd_r     <= bus.in_rd;
      wen_r    <= wen_s;
    end else begin
      inputa_r <= inputa_r;
      inputb_r <= inputb_r;
      rs2_r    <= rs2_r;
      pc_r     <= pc_r;
      aluop_r  <= aluop_r;
      rd_r     <= rd_r;
      wen_r    <= wen_r;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.inputa       = inputa_r;
  assign bus.inputb       = inputb_r;
  assign bus.ALUOp        = aluop_r;
  assign bus.out_rs2_data = rs2_r;
  assign bus.out_pc       = pc_r;
  assign bus.out_rd       = rd_r;
  assign bus.out_wen      = wen_r;

endmodule

// File: tb/tb_ysyx_220053_id_ex_stage.sv
// Bench for the ID->EX stage: directed vector table, hand-written handshake/flush/reset
// sequences and a random phase checked against a transaction-level model.
module tb_ysyx_220053_id_ex_stage;
  localparam int XLEN = 64;
  localparam int OPW  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_220053_id_ex_if #(.XLEN(XLEN), .OPW(OPW)) bus ();
  ysyx_220053_id_ex_stage #(.XLEN(XLEN), .OPW(OPW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Model of the single held entry.
  logic        m_valid;
  logic [63:0] m_a, m_b, m_rs2, m_pc;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  logic        m_wen;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [63:0] d1, d2, pc, imm;
    logic        asel, bsel;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wen;
    logic        ew;
    logic [4:0]  er;
    logic [63:0] ed;
    logic        ww;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic [63:0] ea, eb, ers2;
    logic        ewen;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mfwd(input logic [4:0] a, input logic [63:0] rf);
    if (a == 5'd0) return 64'd0;
    if (bus.exm_wen && bus.exm_rd == a) return bus.exm_data;
    if (bus.wb_wen && bus.wb_rd == a) return bus.wb_data;
    return rf;
  endfunction

  task automatic drive_vec(input vec_t v);
    bus.in_rs1_addr = v.rs1;  bus.in_rs2_addr = v.rs2;
    bus.in_rs1_data = v.d1;   bus.in_rs2_data = v.d2;
    bus.in_pc = v.pc;         bus.in_imm = v.imm;
    bus.in_asel = v.asel;     bus.in_bsel = v.bsel;
    bus.in_aluop = v.op;      bus.in_rd = v.rd;  bus.in_wen = v.wen;
    bus.exm_wen = v.ew;       bus.exm_rd = v.er; bus.exm_data = v.ed;
    bus.wb_wen = v.ww;        bus.wb_rd = v.wr;  bus.wb_data = v.wd;
  endtask

  task automatic check_model();
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_valid});
    if (m_valid) begin
      chk("inputa", bus.inputa, m_a);
      chk("inputb", bus.inputb, m_b);
      chk("aluop", {60'd0, bus.ALUOp}, {60'd0, m_op});
      chk("rs2_data", bus.out_rs2_data, m_rs2);
      chk("out_pc", bus.out_pc, m_pc);
      chk("out_rd", {59'd0, bus.out_rd}, {59'd0, m_rd});
      chk("out_wen", {63'd0, bus.out_wen}, {63'd0, m_wen});
    end
  endtask

  // One clock with inputs already applied: check in_ready, clock, advance model, check outputs.
  task automatic cycle();
    logic cap, rdy;
    logic [63:0] f1, f2;
    #1;
    rdy = !m_valid || bus.out_ready;
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, rdy});
    cap = bus.in_valid && rdy && !bus.flush;
    f1 = mfwd(bus.in_rs1_addr, bus.in_rs1_data);
    f2 = mfwd(bus.in_rs2_addr, bus.in_rs2_data);
    @(posedge clk);
    if (bus.flush) m_valid = 1'b0;
    else if (cap) begin
      m_valid = 1'b1;
      m_a   = bus.in_asel ? bus.in_pc : f1;
      m_b   = bus.in_bsel ? bus.in_imm : f2;
      m_rs2 = f2;
      m_pc  = bus.in_pc;
      m_op  = bus.in_aluop;
      m_rd  = bus.in_rd;
      m_wen = bus.in_wen && (bus.in_rd != 5'd0);
    end else if (bus.out_ready) m_valid = 1'b0;
    #1;
    check_model();
  endtask

  initial begin
    vecs[0] = '{5'd5, 5'd6, 64'h10, 64'h20, 64'h1000, 64'h8, 1'b0, 1'b1, 4'h0, 5'd7, 1'b1,
                1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h10, 64'h8, 64'h20, 1'b1};
    vecs[1] = '{5'd3, 5'd4, 64'hCC, 64'h44, 64'h1004, 64'h0, 1'b0, 1'b0, 4'h0, 5'd9, 1'b1,
                1'b1, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB, 64'hAA, 64'h44, 64'h44, 1'b1};
    vecs[2] = '{5'd3, 5'd4, 64'hCC, 64'h44, 64'h1008, 64'h0, 1'b0, 1'b0, 4'h0, 5'd9, 1'b1,
                1'b0, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB, 64'hBB, 64'h44, 64'h44, 1'b1};
    vecs[3] = '{5'd0, 5'd4, 64'h77, 64'h44, 64'h100C, 64'h0, 1'b0, 1'b0, 4'h1, 5'd9, 1'b1,
                1'b1, 5'd0, 64'hFF, 1'b1, 5'd0, 64'hEE, 64'h0, 64'h44, 64'h44, 1'b1};
    vecs[4] = '{5'd1, 5'd7, 64'h31, 64'h11, 64'h8000_0000, 64'h99, 1'b1, 1'b0, 4'h8, 5'd2, 1'b1,
                1'b1, 5'd9, 64'h1, 1'b1, 5'd7, 64'h55, 64'h8000_0000, 64'h55, 64'h55, 1'b1};
    vecs[5] = '{5'd7, 5'd7, 64'h11, 64'h11, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b1, 4'h3,
                5'd4, 1'b0, 1'b1, 5'd7, 64'hDEAD, 1'b1, 5'd7, 64'h55,
                64'hDEAD, 64'hFFFF_FFFF_FFFF_FFF0, 64'hDEAD, 1'b0};
    vecs[6] = '{5'd0, 5'd0, 64'h5, 64'h6, 64'h3000, 64'h1234_5000, 1'b0, 1'b1, 4'hF, 5'd0, 1'b1,
                1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h1234_5000, 64'h0, 1'b0};
    vecs[7] = '{5'd31, 5'd31, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'h4000, 64'h0,
                1'b0, 1'b0, 4'h7, 5'd31, 1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 64'h0123,
                64'h0123, 64'h0123, 64'h0123, 1'b1};

    // Reset state.
    rst_n = 1'b0;
    drive_vec(vecs[0]);
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    m_valid = 1'b0; m_a = 64'd0; m_b = 64'd0; m_rs2 = 64'd0; m_pc = 64'd0;
    m_op = 4'd0; m_rd = 5'd0; m_wen = 1'b0;
    #12;
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_inputa", bus.inputa, 64'd0);
    chk("rst_inputb", bus.inputb, 64'd0);
    chk("rst_aluop", {60'd0, bus.ALUOp}, 64'd0);
    chk("rst_wen", {63'd0, bus.out_wen}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table, back-to-back with out_ready high.
    for (int i = 0; i < 8; i++) begin
      drive_vec(vecs[i]);
      bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.flush = 1'b0;
      cycle();
      chk($sformatf("vec%0d_valid", i), {63'd0, bus.out_valid}, 64'd1);
      chk($sformatf("vec%0d_a", i), bus.inputa, vecs[i].ea);
      chk($sformatf("vec%0d_b", i), bus.inputb, vecs[i].eb);
      chk($sformatf("vec%0d_rs2", i), bus.out_rs2_data, vecs[i].ers2);
      chk($sformatf("vec%0d_op", i), {60'd0, bus.ALUOp}, {60'd0, vecs[i].op});
      chk($sformatf("vec%0d_wen", i), {63'd0, bus.out_wen}, {63'd0, vecs[i].ewen});
    end

    // Backpressure: held entry frozen for three cycles, then replaced on the releasing edge.
    drive_vec(vecs[0]); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cycle();
    drive_vec(vecs[4]); bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_hold_a", bus.inputa, vecs[0].ea);
      chk("bp_hold_b", bus.inputb, vecs[0].eb);
    end
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_b2b_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("bp_b2b_a", bus.inputa, vecs[4].ea);

    // Flush with a capturable instruction present.
    drive_vec(vecs[5]); bus.flush = 1'b1;
    cycle();
    chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    cycle();
    chk("flush_idle", {63'd0, bus.out_valid}, 64'd0);

    // Asynchronous reset while holding a valid entry.
    drive_vec(vecs[1]); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    cycle();
    chk("pre_rst_valid", {63'd0, bus.out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("async_rst_inputa", bus.inputa, 64'd0);
    chk("async_rst_rd", {59'd0, bus.out_rd}, 64'd0);
    m_valid = 1'b0;
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.out_ready   = ($urandom_range(0, 2) != 0);
      bus.flush       = ($urandom_range(0, 9) == 0);
      bus.in_rs1_addr = 5'($urandom_range(0, 7));
      bus.in_rs2_addr = 5'($urandom_range(0, 7));
      bus.in_rs1_data = {$urandom, $urandom};
      bus.in_rs2_data = {$urandom, $urandom};
      bus.in_pc       = {$urandom, $urandom};
      bus.in_imm      = {$urandom, $urandom};
      bus.in_asel     = 1'($urandom_range(0, 1));
      bus.in_bsel     = 1'($urandom_range(0, 1));
      bus.in_aluop    = 4'($urandom_range(0, 15));
      bus.in_rd       = 5'($urandom_range(0, 7));
      bus.in_wen      = 1'($urandom_range(0, 1));
      bus.exm_wen     = 1'($urandom_range(0, 1));
      bus.exm_rd      = 5'($urandom_range(0, 7));
      bus.exm_data    = {$urandom, $urandom};
      bus.wb_wen      = 1'($urandom_range(0, 1));
      bus.wb_rd       = 5'($urandom_range(0, 7));
      bus.wb_data     = {$urandom, $urandom};
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
